uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path between N_REQ byte-stream clients by writing their bytes into the shared TX FIFO that the UART transmit state machine drains.
- Round-robin arbitration with packet lock: a client keeps the grant until it signals end of packet or hits the MAX_BURST fairness cap.
- Sits between client logic (CPU/debug/log sources) and the TX FIFO write port. Baud timing and serialisation are handled downstream.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  arbiter enable; when low, no new grant is issued
- req_valid_i  in  N_REQ  per-client byte valid
- req_data_i  in  8*N_REQ  per-client byte; client k uses bits [8k+7:8k]
- req_last_i  in  N_REQ  per-client end-of-packet flag, qualified by valid
- req_ready_o  out  N_REQ  per-client accept; a beat transfers when valid&ready
- fifo_full_i  in  1  TX FIFO full
- fifo_wr_en_o  out  1  TX FIFO write strobe
- fifo_wr_data_o  out  8  TX FIFO write data
- grant_o  out  N_REQ  one-hot current owner, all-zero when idle
- busy_o  out  1  high while in XFER

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant_o=0, rr pointer=0, burst count=0, busy_o=0. req_ready_o=0 and fifo_wr_en_o=0 because they are combinational from the reset state.
- States:
  - IDLE: if enable_i and |req_valid_i, pick the winner, load grant (one-hot), clear burst count, go to XFER. Otherwise stay in IDLE.
  - XFER: transfer beats until a release condition occurs, then go to IDLE.
- Winner: the first index with req_valid_i=1 searching upward from the rr pointer, wrapping N_REQ-1 to 0.
- In XFER:
  - req_ready_o[k] = grant_o[k] & ~fifo_full_i (combinational).
  - fifo_wr_en_o = |(req_valid_i & req_ready_o).
  - fifo_wr_data_o = byte of the granted client. Zero when no client is granted.
  - Write latency from the accepted beat is 0 cycles (same-cycle write).
- Burst count increments on each beat.
- Release (state to IDLE next cycle, grant cleared) on any of:
  - a beat with req_last_i of the granted client = 1
  - a beat that makes the burst count equal MAX_BURST
  - enable_i=0 in a cycle with no beat
- On release, rr pointer = granted index + 1 mod N_REQ. The last owner becomes lowest priority.
- There is a minimum 1-cycle IDLE gap between grants. That cycle has no grant and no write.
- fifo_full_i=1 stalls: ready=0 and no write. The grant is held, the count is unchanged, and there is no timeout.
- If the granted client drops valid mid-packet, the grant is held and it waits. Only last, the cap, or disable releases it.
- enable_i=0 while a beat is transferring: that beat completes and the release happens in the next no-beat cycle.
- Each burst counter increment is a +1 count capped by the release. The counter is never compared past MAX_BURST.
- A reset mid-packet drops the grant immediately. Bytes already written remain in the FIFO, so a partial packet is possible and clients must tolerate it.
- Valid from non-granted clients is ignored. Their ready is always 0.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, XFER)
  - the byte width constant (8)
  - a function that computes the burst counter width, $clog2(MAX_BURST+1)
- One natural sub-module: uart_rr_picker. It is combinational and takes req vector + pointer and returns a one-hot winner + valid.

Test Plan:
- Single client 2 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, FIFO never full -> grant_o=4'b0100, three consecutive writes of 0x41,0x42,0x43, IDLE 1 cycle later, pointer=3.
- All four clients continuously valid, 2-byte packets -> grants in order 0,1,2,3,0. Each grant writes exactly 2 bytes, with a 1-cycle gap between grants.
- Client 0 streams 40 bytes with no last, MAX_BURST=16, client 1 valid -> client 0 writes 16 bytes, then client 1 is granted, then client 0 resumes for the next 16.
- fifo_full_i asserted for 5 cycles mid-packet -> fifo_wr_en_o=0 and req_ready_o=0 for those 5 cycles, no byte lost or duplicated, grant held.
- Assert enable_i=0 during a granted client's valid gap -> release next cycle, no new grant while disabled. Re-enable -> arbitration resumes from the updated pointer.
- Assert rst_n=0 asynchronously mid-packet (between clock edges) -> grant_o, busy_o and fifo_wr_en_o go to 0 immediately. After deassert, the first grant goes to the lowest valid index (pointer=0).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Holds the FSM state enum, the byte width and the burst counter width helper.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    // Counter must be able to hold the value MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
// Ports: req_i request vector, ptr_i start index, gnt_o one-hot winner, valid_o any winner.
module uart_rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX FIFO write port.
// Ports: clk/rst_n, enable_i, per-client req_valid_i/req_data_i/req_last_i ->
// req_ready_o, fifo_full_i -> fifo_wr_en_o/fifo_wr_data_o, grant_o, busy_o.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [BYTE_W*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic                    fifo_full_i,
    output logic                    fifo_wr_en_o,
    output logic [BYTE_W-1:0]       fifo_wr_data_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = cnt_width(MAX_BURST);

    state_e           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [PW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;

    logic [N_REQ-1:0] pick_gnt;
    logic             pick_vld;
    logic             beat;
    logic             last_beat;
    logic             cap_hit;
    logic [CW-1:0]    cnt_d;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    ptr_d;

    uart_rr_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_vld)
    );

    // grant_q is all-zero outside XFER, so ready and data need no state qualifier.
    always_comb begin
        req_ready_o    = grant_q & {N_REQ{~fifo_full_i}};
        beat           = |(req_valid_i & req_ready_o);
        last_beat      = |(req_valid_i & req_ready_o & req_last_i);
        fifo_wr_en_o   = beat;
        fifo_wr_data_o = '0;
        gidx           = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                fifo_wr_data_o = req_data_i[BYTE_W*k +: BYTE_W];
                gidx           = PW'(k);
            end
        end
        cnt_d   = cnt_q + 1'b1;
        cap_hit = (cnt_d == CW'(MAX_BURST));
        ptr_d   = (gidx == PW'(N_REQ-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable_i && pick_vld) begin
                        grant_q <= pick_gnt;
                        cnt_q   <= '0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    // A transferring beat always completes; disable only
                    // releases in a cycle without a beat.
                    if (beat) begin
                        cnt_q <= cnt_d;
                        if (last_beat || cap_hit) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_d;
                            state_q <= IDLE;
                        end
                    end else if (!enable_i) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter against an integer-level reference model.
// Client packets live in per-client queues; expected FIFO bytes queue for the monitor.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int MAX = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable_i = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic [N-1:0]   req_ready_o;
    logic           fifo_full_i = 1'b0;
    logic           fifo_wr_en_o;
    logic [7:0]     fifo_wr_data_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (MAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_last_i     (req_last_i),
        .req_ready_o    (req_ready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_o        (grant_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] cq [N][$];
    logic [7:0] exp_q [$];

    // Reference model: owner index (-1 = idle), rotation start, bytes in grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && fifo_wr_en_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_data: unexpected write %0h at %0t",
                         fifo_wr_data_o, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (fifo_wr_data_o !== e) begin
                    n_fail++;
                    $display("FAIL wr_data: got %0h expected %0h at %0t",
                             fifo_wr_data_o, e, $time);
                end
            end
        end
    end

    task automatic load(input int k, input int n, input bit last,
                        input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            logic [8:0] b;
            b[7:0] = base + 8'(i);
            b[8]   = last && (i == n - 1);
            cq[k].push_back(b);
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) cq[k].delete();
        exp_q.delete();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic [N-1:0] want, input logic full,
                         input logic en);
        logic [N-1:0] v, eg, er;
        logic         beat, rel, lastb;
        bit           found;
        v = '0;
        for (int k = 0; k < N; k++) begin
            req_data_i[8*k +: 8] = 8'($urandom);
            req_last_i[k]        = 1'($urandom);
            if (want[k] && cq[k].size() > 0) begin
                v[k]                 = 1'b1;
                req_data_i[8*k +: 8] = cq[k][0][7:0];
                req_last_i[k]        = cq[k][0][8];
            end
        end
        req_valid_i = v;
        fifo_full_i = full;
        enable_i    = en;
        eg   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        er   = (m_owner >= 0 && !full) ? eg : '0;
        beat = (m_owner >= 0) && !full && v[m_owner];
        if (beat) exp_q.push_back(cq[m_owner][0][7:0]);
        @(negedge clk);
        chk("grant", 32'(grant_o), 32'(eg));
        chk("ready", 32'(req_ready_o), 32'(er));
        chk("wr_en", 32'(fifo_wr_en_o), 32'(beat));
        chk("busy", 32'(busy_o), 32'(m_owner >= 0));
        if (m_owner < 0) chk("idle_data", 32'(fifo_wr_data_o), 32'h0);
        @(posedge clk);
        if (m_owner < 0) begin
            found = 0;
            if (en) begin
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (m_ptr + i) % N;
                    if (!found && v[c]) begin
                        found   = 1;
                        m_owner = c;
                        m_cnt   = 0;
                    end
                end
            end
        end else begin
            rel = 0;
            if (beat) begin
                lastb = cq[m_owner][0][8];
                void'(cq[m_owner].pop_front());
                m_cnt++;
                if (lastb || m_cnt == MAX) rel = 1;
            end else if (!en) begin
                rel = 1;
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        #1;
    endtask

    function automatic bit pending(input logic [N-1:0] want);
        for (int k = 0; k < N; k++)
            if (want[k] && cq[k].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drain(input logic [N-1:0] want, input int maxc);
        int c;
        c = 0;
        while ((pending(want) || m_owner >= 0) && c < maxc) begin
            cycle(want, 1'b0, 1'b1);
            c++;
        end
        if (pending(want)) chk("drain_timeout", 32'(c), 32'(maxc + 1));
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        enable_i    = 1'b0;
        req_valid_i = '0;
        fifo_full_i = 1'b0;
        clear_all();
        @(negedge clk);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single client 2, three-byte packet.
        load(2, 3, 1, 8'h41);
        drain(4'b0100, 20);
        cycle(4'b0000, 1'b0, 1'b1);

        // All four clients with 2-byte packets; rotation 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < N; k++) begin
            load(k, 2, 1, 8'(16 * k));
            load(k, 2, 1, 8'(16 * k + 8));
        end
        drain(4'b1111, 60);

        // Client 0 long stream hits the burst cap; client 1 interleaves.
        do_reset();
        load(0, 40, 0, 8'h80);
        load(1, 4, 1, 8'h10);
        drain(4'b0011, 150);

        // FIFO full for 5 cycles mid-packet.
        do_reset();
        load(1, 10, 1, 8'h20);
        repeat (4) cycle(4'b0010, 1'b0, 1'b1);
        repeat (5) cycle(4'b0010, 1'b1, 1'b1);
        drain(4'b0010, 30);

        // Disable during a valid gap of the owner, then re-enable.
        do_reset();
        load(3, 6, 1, 8'h30);
        load(0, 2, 1, 8'h50);
        repeat (3) cycle(4'b1000, 1'b0, 1'b1);
        repeat (2) cycle(4'b0000, 1'b0, 1'b1);
        repeat (2) cycle(4'b0000, 1'b0, 1'b0);
        repeat (3) cycle(4'b1001, 1'b0, 1'b0);
        drain(4'b1001, 40);

        // Asynchronous reset between clock edges mid-packet.
        do_reset();
        load(0, 10, 0, 8'h60);
        repeat (4) cycle(4'b0001, 1'b0, 1'b1);
        req_valid_i = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant_o), 32'h0);
        chk("async_busy", 32'(busy_o), 32'h0);
        chk("async_wr_en", 32'(fifo_wr_en_o), 32'h0);
        do_reset();
        load(1, 2, 1, 8'h70);
        load(3, 2, 1, 8'h78);
        drain(4'b1010, 30);

        // Randomized traffic.
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            logic [N-1:0] want;
            for (int k = 0; k < N; k++) begin
                if (cq[k].size() < 2)
                    load(k, $urandom_range(1, 24), 1, 8'($urandom));
                want[k] = ($urandom_range(0, 3) != 0);
            end
            cycle(want, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 19) != 0);
        end
        repeat (2) cycle(4'b0000, 1'b0, 1'b1);

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
